// File: rtl/fast_round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// fast_round_robin_arbiter
//
// Purpose:
//   Combinational round-robin arbiter. A priority pointer P selects the
//   highest-priority channel; the grant is the first active request found
//   searching upward from P with wrap-around. The search is done with two
//   parallel priority encoders (masked to indices >= P, and unmasked); the
//   masked result wins whenever any masked request exists. Grant has zero
//   cycle latency and is not registered.
//
// Parameters:
//   SIZE            - number of request/grant channels (>= 2)
//   ROTATE_ON_GRANT - 0: P advances by one every clock
//                     1: P moves to (granted index + 1) on a grant, holds
//                        otherwise
//
// Ports:
//   clock    in   clock, rising-edge
//   resetn   in   synchronous active-low reset (P <- 0)
//   requests in   [SIZE-1:0] request vector, bit i = channel i requests
//   grant    out  [SIZE-1:0] one-hot grant, zero when no requests
//
// Optional build macro:
//   FAST_ROUND_ROBIN_ARBITER_ASSERTIONS_EN - compiles in one-hot / subset /
//   liveness checks on grant while out of reset.
// -----------------------------------------------------------------------------
module fast_round_robin_arbiter #(
  parameter int SIZE            = 4,
  parameter int ROTATE_ON_GRANT = 0
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [SIZE-1:0] requests,
  output logic [SIZE-1:0] grant
);

  localparam int PTR_W = $clog2(SIZE);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(SIZE - 1);
  localparam logic [SIZE-1:0]  ONE_VEC  = {{(SIZE-1){1'b0}}, 1'b1};

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [SIZE-1:0]  mask;
  logic [SIZE-1:0]  masked_req;
  logic [SIZE-1:0]  masked_gnt;
  logic [SIZE-1:0]  plain_gnt;
  logic [PTR_W-1:0] gnt_idx;

  // Increment modulo SIZE; explicit wrap so non-power-of-two sizes work.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    return (v == LAST_IDX) ? '0 : v + PTR_W'(1);
  endfunction

  // Thermometer mask: bit i set for i >= P.
  always_comb begin
    mask = '0;
    for (int i = 0; i < SIZE; i++) begin
      mask[i] = (PTR_W'(i) >= ptr_q);
    end
  end

  assign masked_req = requests & mask;

  // x & -x isolates the lowest set bit: a flat priority encoder with no loop.
  assign masked_gnt = masked_req & (~masked_req + ONE_VEC);
  assign plain_gnt  = requests   & (~requests   + ONE_VEC);

  assign grant = (|masked_req) ? masked_gnt : plain_gnt;

  // One-hot to index of the granted channel (grant is at most one-hot).
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (grant[i]) gnt_idx = gnt_idx | PTR_W'(i);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ROTATE_ON_GRANT == 0) begin
      ptr_d = wrap_inc(ptr_q);
    end else if (|grant) begin
      ptr_d = wrap_inc(gnt_idx);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

`ifdef FAST_ROUND_ROBIN_ARBITER_ASSERTIONS_EN
  always_ff @(posedge clock) begin
    if (resetn) begin
      if ($countones(grant) > 1)
        $error("%0t: grant not one-hot: requests=%b grant=%b", $time, requests, grant);
      if ((grant & ~requests) != '0)
        $error("%0t: grant without request: requests=%b grant=%b", $time, requests, grant);
      if ((requests != '0) && ($countones(grant) != 1))
        $error("%0t: requests pending but no single grant: requests=%b grant=%b",
               $time, requests, grant);
    end
  end
`else
`endif

endmodule

// File: tb/tb_fast_round_robin_arbiter.sv
// Directed bench for fast_round_robin_arbiter, SIZE=4, ROTATE_ON_GRANT=0.
module tb_fast_round_robin_arbiter;

  logic       clock;
  logic       resetn;
  logic [3:0] requests;
  logic [3:0] grant;

  int n_cmp;
  int n_bad;
  int exp_ptr;

  fast_round_robin_arbiter #(.SIZE(4), .ROTATE_ON_GRANT(0)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .requests (requests),
    .grant    (grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle: inputs applied after the falling edge, grant sampled
  // 1 time unit later, then the rising edge is consumed and the expected
  // pointer advanced.
  task automatic drive_cycle(input logic [3:0] req, input logic rst_n,
                             output logic [3:0] g);
    @(negedge clock);
    requests = req;
    resetn   = rst_n;
    #1;
    g = grant;
    @(posedge clock);
    exp_ptr = rst_n ? (exp_ptr + 1) % 4 : 0;
  endtask

  // Serial reference search, upward from p with wrap.
  function automatic logic [3:0] ref_grant(input logic [3:0] req, input int p);
    logic [3:0] r;
    r = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (r == 4'b0000 && req[(p + k) % 4]) r[(p + k) % 4] = 1'b1;
    end
    return r;
  endfunction

  task automatic do_reset();
    logic [3:0] g;
    drive_cycle(4'b0000, 1'b0, g);
  endtask

  task automatic test_reset();
    logic [3:0] g;
    drive_cycle(4'b1111, 1'b0, g);
    drive_cycle(4'b1111, 1'b0, g);
    n_cmp++;
    if (g !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_grant: got %b want %b", g, 4'b0001);
    end
    drive_cycle(4'b0110, 1'b0, g);
    n_cmp++;
    if (g !== 4'b0010) begin
      n_bad++;
      $display("FAIL reset_grant_partial: got %b want %b", g, 4'b0010);
    end
  endtask

  task automatic test_single();
    logic [3:0] g;
    logic [3:0] pats [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) begin
        drive_cycle(pats[p], 1'b1, g);
        n_cmp++;
        if (g !== pats[p]) begin
          n_bad++;
          $display("FAIL single_req p%0d c%0d: got %b want %b", p, c, g, pats[p]);
        end
      end
    end
  endtask

  task automatic test_all_requests();
    logic [3:0] g;
    logic [3:0] orv;
    logic [3:0] exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    orv = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(4'b1111, 1'b1, g);
      orv = orv | g;
      n_cmp++;
      if (g !== exp[c]) begin
        n_bad++;
        $display("FAIL all_req c%0d: got %b want %b", c, g, exp[c]);
      end
    end
    n_cmp++;
    if (orv !== 4'b1111) begin
      n_bad++;
      $display("FAIL all_req_or: got %b want %b", orv, 4'b1111);
    end
  endtask

  task automatic test_idle();
    logic [3:0] g;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive_cycle(4'b0000, 1'b1, g);
      n_cmp++;
      if (g !== 4'b0000) begin
        n_bad++;
        $display("FAIL idle c%0d: got %b want %b", c, g, 4'b0000);
      end
    end
    // P rotated through 6 idle cycles, so P = 2 now.
    drive_cycle(4'b1111, 1'b1, g);
    n_cmp++;
    if (g !== 4'b0100) begin
      n_bad++;
      $display("FAIL idle_rotation: got %b want %b", g, 4'b0100);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] g;
    logic [3:0] exp [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0001};
    for (int p = 1; p < 4; p++) begin
      do_reset();
      for (int c = 0; c < p; c++) drive_cycle(4'b0000, 1'b1, g);
      drive_cycle(4'b0011, 1'b1, g);
      n_cmp++;
      if (g !== exp[p]) begin
        n_bad++;
        $display("FAIL wrap P=%0d: got %b want %b", p, g, exp[p]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] g;
    // P runs 0,1,2,3,0,1 across these cycles.
    logic [3:0] rq  [6] = '{4'b1010, 4'b1100, 4'b0011, 4'b0110, 4'b1000, 4'b0101};
    logic [3:0] exp [6] = '{4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0100};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive_cycle(rq[c], 1'b1, g);
      n_cmp++;
      if (g !== exp[c]) begin
        n_bad++;
        $display("FAIL back_to_back c%0d: got %b want %b", c, g, exp[c]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] g;
    do_reset();
    drive_cycle(4'b1111, 1'b1, g);
    drive_cycle(4'b1111, 1'b1, g);
    // Reset cycle itself still sees the running pointer (P = 2).
    drive_cycle(4'b1111, 1'b0, g);
    n_cmp++;
    if (g !== 4'b0100) begin
      n_bad++;
      $display("FAIL reset_mid_during: got %b want %b", g, 4'b0100);
    end
    drive_cycle(4'b1111, 1'b1, g);
    n_cmp++;
    if (g !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_mid_first: got %b want %b", g, 4'b0001);
    end
    drive_cycle(4'b1111, 1'b1, g);
    n_cmp++;
    if (g !== 4'b0010) begin
      n_bad++;
      $display("FAIL reset_mid_second: got %b want %b", g, 4'b0010);
    end
  endtask

  task automatic test_random_fairness();
    logic [3:0] g;
    logic [3:0] r;
    logic [3:0] e;
    int n_req [4];
    int n_gnt [4];
    for (int i = 0; i < 4; i++) begin
      n_req[i] = 0;
      n_gnt[i] = 0;
    end
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      r = 4'($urandom_range(0, 15));
      e = ref_grant(r, exp_ptr);
      drive_cycle(r, 1'b1, g);
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL random c%0d req=%b: got %b want %b", c, r, g, e);
      end
      for (int i = 0; i < 4; i++) begin
        if (r[i]) n_req[i]++;
        if (g[i] === 1'b1) n_gnt[i]++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (n_req[i] == 0 || n_gnt[i] * 4 < n_req[i] || n_gnt[i] * 4 > n_req[i] * 3) begin
        n_bad++;
        $display("FAIL fairness ch%0d: got %0d grants / %0d requests, want ratio in [1/4,3/4]",
                 i, n_gnt[i], n_req[i]);
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    exp_ptr  = 0;
    resetn   = 1'b0;
    requests = 4'b0000;
    test_reset();
    test_single();
    test_all_requests();
    test_idle();
    test_wrap();
    test_back_to_back();
    test_reset_mid_run();
    test_random_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
